ball_physics_engine: RTL

//  Per-frame kinematics engine for NUM_BALLS balls. One frame_tick starts a sequential pass; each ball in turn

---
 rtl/ball_physics_engine_if.sv | 21 ++
 rtl/ball_physics_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_physics_engine_if.sv
// Collision-map lookup channel between the physics engine (master) and the collision ROM (slave).
interface ball_physics_engine_if #(
  parameter int COORD_W = 10
) ();
  logic               coll_req;
  logic [COORD_W-1:0] coll_x;
  logic [COORD_W-1:0] coll_y;
  logic               coll_ack;
  logic               coll_hit_x;
  logic               coll_hit_y;

  modport master (
    output coll_req, coll_x, coll_y,
    input  coll_ack, coll_hit_x, coll_hit_y
  );

  modport slave (
    input  coll_req, coll_x, coll_y,
    output coll_ack, coll_hit_x, coll_hit_y
  );
endinterface

// File: rtl/ball_physics_engine.sv
// Per-frame kinematics engine: on each accepted frame_tick, every ball in turn gets a collision lookup,
// wall reflection, edge bounce, button thrust, periodic deceleration and a speed clamp.
module ball_physics_engine #(
  parameter int NUM_BALLS    = 4,
  parameter int COORD_W      = 10,
  parameter int SPEED_W      = 8,
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int MAX_SPEED    = 20,
  parameter int DECEL        = 1,
  parameter int DECEL_PERIOD = 6,
  parameter int INIT_X       = 200,
  parameter int INIT_Y       = 300,
  parameter int INIT_STEP    = 64,
  localparam int SEL_W       = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
  input  logic                           pixel_clk,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic                           btn_u,
  input  logic                           btn_d,
  input  logic                           btn_l,
  input  logic                           btn_r,
  input  logic [SEL_W-1:0]               ctrl_sel,
  ball_physics_engine_if.master          coll,
  output logic [NUM_BALLS*COORD_W-1:0]   ball_x_flat,
  output logic [NUM_BALLS*COORD_W-1:0]   ball_y_flat,
  output logic [NUM_BALLS*SPEED_W-1:0]   speed_x_flat,
  output logic [NUM_BALLS*SPEED_W-1:0]   speed_y_flat,
  output logic                           busy,
  output logic                           update_done,
  output logic                           overrun
);

  localparam int IW    = SPEED_W + COORD_W + 1;
  localparam int CNT_W = (DECEL_PERIOD > 1) ? $clog2(DECEL_PERIOD) : 1;

  localparam logic [SEL_W-1:0]      LAST_IDX = SEL_W'(NUM_BALLS - 1);
  localparam logic [SEL_W:0]        NB_L     = (SEL_W + 1)'(NUM_BALLS);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DECEL_PERIOD - 1);
  localparam logic [COORD_W-1:0]    X_LIM    = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0]    Y_LIM    = COORD_W'(V_ACTIVE - 1);
  localparam logic signed [IW-1:0]  ONE_S    = IW'(1);
  localparam logic signed [IW-1:0]  DEC_S    = IW'(DECEL);
  localparam logic signed [IW-1:0]  MAX_S    = IW'(MAX_SPEED);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_UPD  = 2'd2
  } state_t;

  state_t               state_r, next_state_s;
  logic [SEL_W-1:0]     idx_r, next_idx_s;
  logic                 tick_accept_s, upd_en_s, last_s, overrun_s;

  logic [COORD_W-1:0]   ball_x_r  [NUM_BALLS];
  logic [COORD_W-1:0]   ball_y_r  [NUM_BALLS];
  logic [SPEED_W-1:0]   speed_x_r [NUM_BALLS];
  logic [SPEED_W-1:0]   speed_y_r [NUM_BALLS];

  logic                 btn_u_r, btn_d_r, btn_l_r, btn_r_r, decel_r;
  logic [SEL_W-1:0]     sel_r;
  logic                 hit_x_r, hit_y_r;
  logic [CNT_W-1:0]     frame_cnt_r;
  logic                 coll_req_r, busy_r, update_done_r, overrun_r;
  logic [COORD_W-1:0]   coll_x_r, coll_y_r;

  logic [COORD_W+IW-1:0] mx_s, my_s;
  logic [SPEED_W-1:0]    new_vx_s, new_vy_s;
  logic                  ctl_s;

  // Reflect, advance and bounce one axis; returns {new position, post-bounce speed}.
  function automatic logic [COORD_W+IW-1:0] move_axis(
    input logic [COORD_W-1:0] pos,
    input logic [SPEED_W-1:0] vel,
    input logic               hit,
    input logic [COORD_W-1:0] lim
  );
    logic signed [IW-1:0] p, v, l;
    v = {{(IW-SPEED_W){vel[SPEED_W-1]}}, vel};
    p = {{(IW-COORD_W){1'b0}}, pos};
    l = {{(IW-COORD_W){1'b0}}, lim};
    if (hit) begin
      v = -v;
    end else begin
      v = v;
    end
    p = p + v;
    if (p[IW-1]) begin
      p = {IW{1'b0}};
      v = -v;
    end else if (p > l) begin
      p = l;
      v = -v;
    end else begin
      p = p;
    end
    return {p[COORD_W-1:0], v};
  endfunction

  // Thrust, periodic deceleration toward zero, then symmetric saturation.
  function automatic logic [SPEED_W-1:0] adjust_vel(
    input logic signed [IW-1:0] vel,
    input logic                 inc,
    input logic                 dec,
    input logic                 decel
  );
    logic signed [IW-1:0] v;
    v = vel;
    if (inc && !dec) begin
      v = v + ONE_S;
    end else if (dec && !inc) begin
      v = v - ONE_S;
    end else begin
      v = v;
    end
    if (decel) begin
      if ((v <= DEC_S) && (v >= -DEC_S)) begin
        v = {IW{1'b0}};
      end else if (v[IW-1]) begin
        v = v + DEC_S;
      end else begin
        v = v - DEC_S;
      end
    end else begin
      v = v;
    end
    if (v > MAX_S) begin
      v = MAX_S;
    end else if (v < -MAX_S) begin
      v = -MAX_S;
    end else begin
      v = v;
    end
    return v[SPEED_W-1:0];
  endfunction

  // State and ball index registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {SEL_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      idx_r   <= next_idx_s;
    end
  end

  // Next-state logic; a tick coincident with update_done still counts as arriving while busy
  always_comb begin
    next_state_s  = state_r;
    next_idx_s    = idx_r;
    tick_accept_s = 1'b0;
    upd_en_s      = 1'b0;
    last_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick && !update_done_r) begin
          next_state_s  = ST_REQ;
          next_idx_s    = {SEL_W{1'b0}};
          tick_accept_s = 1'b1;
        end else begin
          next_state_s  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (coll.coll_ack) begin
          next_state_s = ST_UPD;
        end else begin
          next_state_s = ST_REQ;
        end
      end
      ST_UPD: begin
        upd_en_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          next_state_s = ST_IDLE;
          last_s       = 1'b1;
        end else begin
          next_state_s = ST_REQ;
          next_idx_s   = idx_r + 1'b1;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_idx_s   = {SEL_W{1'b0}};
      end
    endcase
    overrun_s = frame_tick && !tick_accept_s;
  end

  // New kinematics for the ball currently in UPD
  always_comb begin
    mx_s     = move_axis(ball_x_r[idx_r], speed_x_r[idx_r], hit_x_r, X_LIM);
    my_s     = move_axis(ball_y_r[idx_r], speed_y_r[idx_r], hit_y_r, Y_LIM);
    ctl_s    = (sel_r == idx_r) && ({1'b0, sel_r} < NB_L);
    new_vx_s = adjust_vel(mx_s[IW-1:0], ctl_s & btn_r_r, ctl_s & btn_l_r, decel_r);
    new_vy_s = adjust_vel(my_s[IW-1:0], ctl_s & btn_d_r, ctl_s & btn_u_r, decel_r);
  end

  // Datapath: ball state, tick snapshot, lookup channel and status pulses
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        ball_x_r[i]  <= COORD_W'(INIT_X + i * INIT_STEP);
        ball_y_r[i]  <= COORD_W'(INIT_Y);
        speed_x_r[i] <= {SPEED_W{1'b0}};
        speed_y_r[i] <= {SPEED_W{1'b0}};
      end
      btn_u_r       <= 1'b0;
      btn_d_r       <= 1'b0;
      btn_l_r       <= 1'b0;
      btn_r_r       <= 1'b0;
      decel_r       <= 1'b0;
      sel_r         <= {SEL_W{1'b0}};
      hit_x_r       <= 1'b0;
      hit_y_r       <= 1'b0;
      frame_cnt_r   <= {CNT_W{1'b0}};
      coll_req_r    <= 1'b0;
      coll_x_r      <= {COORD_W{1'b0}};
      coll_y_r      <= {COORD_W{1'b0}};
      busy_r        <= 1'b0;
      update_done_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      if (frame_tick) begin
        frame_cnt_r <= (frame_cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : frame_cnt_r + 1'b1;
      end
      if (tick_accept_s) begin
        btn_u_r <= btn_u;
        btn_d_r <= btn_d;
        btn_l_r <= btn_l;
        btn_r_r <= btn_r;
        sel_r   <= ctrl_sel;
        decel_r <= (frame_cnt_r == {CNT_W{1'b0}});
      end
      if ((next_state_s == ST_REQ) && (state_r != ST_REQ)) begin
        coll_x_r <= ball_x_r[next_idx_s];
        coll_y_r <= ball_y_r[next_idx_s];
      end
      if ((state_r == ST_REQ) && coll.coll_ack) begin
        hit_x_r <= coll.coll_hit_x;
        hit_y_r <= coll.coll_hit_y;
      end
      if (upd_en_s) begin
        ball_x_r[idx_r]  <= mx_s[COORD_W+IW-1:IW];
        ball_y_r[idx_r]  <= my_s[COORD_W+IW-1:IW];
        speed_x_r[idx_r] <= new_vx_s;
        speed_y_r[idx_r] <= new_vy_s;
      end
      coll_req_r    <= (next_state_s == ST_REQ);
      busy_r        <= (next_state_s != ST_IDLE);
      update_done_r <= last_s;
      overrun_r     <= overrun_s;
    end
  end

  assign coll.coll_req = coll_req_r;
  assign coll.coll_x   = coll_x_r;
  assign coll.coll_y   = coll_y_r;
  assign busy          = busy_r;
  assign update_done   = update_done_r;
  assign overrun       = overrun_r;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_flat
    assign ball_x_flat[g*COORD_W +: COORD_W]  = ball_x_r[g];
    assign ball_y_flat[g*COORD_W +: COORD_W]  = ball_y_r[g];
    assign speed_x_flat[g*SPEED_W +: SPEED_W] = speed_x_r[g];
    assign speed_y_flat[g*SPEED_W +: SPEED_W] = speed_y_r[g];
  end

endmodule
